// File: rtl/dmem_bridge_pkg.sv
// Shared constants for the data-memory bridge: MMIO map, STATUS layout and UART FSM states.
package dmem_bridge_pkg;

   localparam logic [31:0] MMIO_BASE    = 32'h1000_0000;
   localparam logic [3:0]  TXDATA_OFS   = 4'h0;
   localparam logic [3:0]  STATUS_OFS   = 4'h4;
   localparam logic [3:0]  CYCLE_LO_OFS = 4'h8;
   localparam logic [3:0]  CYCLE_HI_OFS = 4'hC;

   localparam int STAT_FULL_BIT  = 0;
   localparam int STAT_EMPTY_BIT = 1;
   localparam int STAT_BUSY_BIT  = 2;
   localparam int STAT_OVF_BIT   = 3;
   localparam int STAT_CNT_LSB   = 8;
   localparam int STAT_CNT_W     = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/dmem_uart_bridge_uart_tx.sv
// FIFO-buffered 8N1 transmitter with sticky overflow flag.
//  state | meaning
//  IDLE  | line high, waiting for a FIFO byte
//  START | start bit (low) for CLK_DIV cycles
//  DATA  | 8 data bits, LSB first, CLK_DIV cycles each
//  STOP  | stop bit (high); last cycle may pop the next byte back-to-back
module uart_tx
   import dmem_bridge_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int CLK_DIV    = 868
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       i_push,
   input  logic [7:0] i_push_data,
   input  logic       i_overflow_clr,
   output logic       o_full,
   output logic       o_empty,
   output logic [4:0] o_count,
   output logic       o_busy,
   output logic       o_overflow,
   output logic       o_tx
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(CLK_DIV);
   localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);

   logic [7:0]    r_fifo [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   uart_state_t   r_state;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;

   logic w_full, w_empty, w_baud_done, w_pop, w_push_ok;

   assign w_full      = (r_count == CW'(FIFO_DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_baud_done = (r_baud == '0);
   assign w_pop       = !w_empty && ((r_state == IDLE) || (r_state == STOP && w_baud_done));
   // a push into a full FIFO still lands if the same edge frees a slot
   assign w_push_ok   = i_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push_ok) r_fifo[r_wr_ptr] <= i_push_data;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (i_push && !w_push_ok)  r_overflow <= 1'b1;
         else if (i_overflow_clr)   r_overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_shift <= r_fifo[r_rd_ptr];
                  r_baud  <= BAUD_RELOAD;
                  r_state <= START;
               end
            end
            START: begin
               if (w_baud_done) begin
                  r_baud    <= BAUD_RELOAD;
                  r_bit_idx <= '0;
                  r_state   <= DATA;
               end else r_baud <= r_baud - BW'(1);
            end
            DATA: begin
               if (w_baud_done) begin
                  r_baud <= BAUD_RELOAD;
                  if (r_bit_idx == 3'd7) r_state <= STOP;
                  else r_bit_idx <= r_bit_idx + 3'd1;
               end else r_baud <= r_baud - BW'(1);
            end
            STOP: begin
               if (w_baud_done) begin
                  if (w_pop) begin
                     r_shift <= r_fifo[r_rd_ptr];
                     r_baud  <= BAUD_RELOAD;
                     r_state <= START;
                  end else r_state <= IDLE;
               end else r_baud <= r_baud - BW'(1);
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      o_tx = 1'b1;
      case (r_state)
         START:   o_tx = 1'b0;
         DATA:    o_tx = r_shift[r_bit_idx];
         default: o_tx = 1'b1;
      endcase
   end

   assign o_full     = w_full;
   assign o_empty    = w_empty;
   assign o_count    = 5'(r_count);
   assign o_busy     = (r_state != IDLE);
   assign o_overflow = r_overflow;

endmodule

// File: rtl/dmem_uart_bridge.sv
// Data-side memory: word RAM plus MMIO window (UART TX, optional cycle counter).
// Define DMEM_UART_CYCLE_CNT_EN to build the 64-bit cycle counter and its HI shadow.
module dmem_uart_bridge
   import dmem_bridge_pkg::*;
#(
   parameter int RAM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 16,
   parameter int CLK_DIV    = 868
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] i_data_mem_addr,
   input  logic [31:0] i_data_mem_write_data,
   input  logic        i_data_mem_read_en,
   input  logic        i_data_mem_write_en,
   output logic [31:0] o_data_mem_read_data,
   output logic        o_uart_tx
);
   localparam int RAM_AW = $clog2(RAM_WORDS);

   logic [31:0] r_ram [RAM_WORDS];

   logic              w_ram_sel, w_mmio_sel;
   logic [RAM_AW-1:0] w_ram_idx;
   logic [3:0]        w_ofs;
   logic              w_wr_txdata, w_wr_status;
   logic              w_full, w_empty, w_busy, w_overflow;
   logic [4:0]        w_count;
   logic [31:0]       w_status, w_cycle_lo, w_cycle_hi;

   assign w_ram_sel   = (i_data_mem_addr < 32'(RAM_WORDS * 4));
   assign w_ram_idx   = i_data_mem_addr[RAM_AW+1:2];
   assign w_mmio_sel  = (i_data_mem_addr[31:4] == MMIO_BASE[31:4]);
   assign w_ofs       = {i_data_mem_addr[3:2], 2'b00};
   assign w_wr_txdata = i_data_mem_write_en && w_mmio_sel && (w_ofs == TXDATA_OFS);
   assign w_wr_status = i_data_mem_write_en && w_mmio_sel && (w_ofs == STATUS_OFS);

   always_ff @(posedge clk) begin
      if (i_data_mem_write_en && w_ram_sel) r_ram[w_ram_idx] <= i_data_mem_write_data;
   end

   uart_tx #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CLK_DIV    (CLK_DIV)
   ) u_uart_tx (
      .clk            (clk),
      .rstn           (rstn),
      .i_push         (w_wr_txdata),
      .i_push_data    (i_data_mem_write_data[7:0]),
      .i_overflow_clr (w_wr_status),
      .o_full         (w_full),
      .o_empty        (w_empty),
      .o_count        (w_count),
      .o_busy         (w_busy),
      .o_overflow     (w_overflow),
      .o_tx           (o_uart_tx)
   );

`ifdef DMEM_UART_CYCLE_CNT_EN
   logic [63:0] r_cycle;
   logic [31:0] r_cycle_hi;
   logic        w_rd_cycle_lo;

   assign w_rd_cycle_lo = i_data_mem_read_en && w_mmio_sel && (w_ofs == CYCLE_LO_OFS);

   // reading LO freezes the matching HI word so a LO/HI pair is coherent
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_cycle    <= '0;
         r_cycle_hi <= '0;
      end else begin
         r_cycle <= r_cycle + 64'd1;
         if (w_rd_cycle_lo) r_cycle_hi <= r_cycle[63:32];
      end
   end

   assign w_cycle_lo = r_cycle[31:0];
   assign w_cycle_hi = r_cycle_hi;
`else
   assign w_cycle_lo = '0;
   assign w_cycle_hi = '0;
`endif

   always_comb begin
      w_status                                  = '0;
      w_status[STAT_FULL_BIT]                   = w_full;
      w_status[STAT_EMPTY_BIT]                  = w_empty;
      w_status[STAT_BUSY_BIT]                   = w_busy;
      w_status[STAT_OVF_BIT]                    = w_overflow;
      w_status[STAT_CNT_LSB +: STAT_CNT_W]      = w_count;
   end

   always_comb begin
      o_data_mem_read_data = '0;
      if (i_data_mem_read_en) begin
         if (w_ram_sel) o_data_mem_read_data = r_ram[w_ram_idx];
         else if (w_mmio_sel) begin
            case (w_ofs)
               STATUS_OFS:   o_data_mem_read_data = w_status;
               CYCLE_LO_OFS: o_data_mem_read_data = w_cycle_lo;
               CYCLE_HI_OFS: o_data_mem_read_data = w_cycle_hi;
               default:      o_data_mem_read_data = '0;
            endcase
         end
      end
   end

endmodule
